// File: rtl/mdio_master_controller.sv
// Clause-22 MDIO master: takes one 32-bit frame word, emits preamble + frame on MDC/MDIO,
// and captures the 16 PHY data bits for read frames.
module mdio_master_controller #(
  parameter int CLK_DIV       = 10,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transmit_we,
  input  logic [31:0] transmit_data_in,
  output logic        transmit_ready,
  input  logic        receive_re,
  output logic [15:0] receive_data,
  output logic        receive_valid,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  localparam int CNT_MAX = (PREAMBLE_BITS > 16) ? PREAMBLE_BITS : 16;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(13);
  localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_END
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        frame;
  logic               is_read;
  logic [15:0]        rx_shift;

  // mdc doubles as the phase flag: a slot ends on the divider wrap while mdc is high,
  // and frame[31] always holds the bit currently on the wire once the header starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      div            <= '0;
      cnt            <= '0;
      frame          <= '0;
      is_read        <= 1'b0;
      rx_shift       <= '0;
      mdc            <= 1'b0;
      mdio_out       <= 1'b1;
      mdio_oe        <= 1'b0;
      busy           <= 1'b0;
      transmit_ready <= 1'b1;
      receive_valid  <= 1'b0;
      receive_data   <= '0;
    end else begin
      if (receive_re && receive_valid)
        receive_valid <= 1'b0;

      if (state == S_IDLE) begin
        div <= '0;
        mdc <= 1'b0;
        if (transmit_we) begin
          frame          <= transmit_data_in;
          is_read        <= (transmit_data_in[29:28] == 2'b10);
          state          <= S_PRE;
          cnt            <= '0;
          busy           <= 1'b1;
          transmit_ready <= 1'b0;
          mdio_oe        <= 1'b1;
          mdio_out       <= 1'b1;
        end
      end else if (div != DIV_LAST) begin
        div <= div + DIV_W'(1);
      end else begin
        div <= '0;
        mdc <= ~mdc;
        if (!mdc) begin
          if (state == S_DATA && is_read)
            rx_shift <= {rx_shift[14:0], mdio_in};
        end else begin
          cnt <= cnt + CNT_W'(1);
          case (state)
            S_PRE: begin
              if (cnt == PRE_LAST) begin
                state    <= S_HDR;
                cnt      <= '0;
                mdio_out <= frame[31];
              end
            end
            S_HDR: begin
              frame    <= frame << 1;
              mdio_out <= frame[30];
              if (cnt == HDR_LAST) begin
                state   <= S_TA;
                cnt     <= '0;
                mdio_oe <= ~is_read;
                if (is_read)
                  mdio_out <= 1'b1;
              end
            end
            S_TA: begin
              frame    <= frame << 1;
              mdio_out <= is_read ? 1'b1 : frame[30];
              if (cnt == TA_LAST) begin
                state <= S_DATA;
                cnt   <= '0;
              end
            end
            S_DATA: begin
              frame    <= frame << 1;
              mdio_out <= is_read ? 1'b1 : frame[30];
              if (cnt == DATA_LAST) begin
                state    <= S_END;
                cnt      <= '0;
                mdio_out <= 1'b1;
                mdio_oe  <= 1'b0;
              end
            end
            S_END: begin
              state          <= S_IDLE;
              cnt            <= '0;
              busy           <= 1'b0;
              transmit_ready <= 1'b1;
              if (is_read) begin
                receive_data  <= rx_shift;
                receive_valid <= 1'b1;
              end
            end
            default: begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master_controller.sv
// Directed bench for mdio_master_controller (CLK_DIV=2, PREAMBLE_BITS=32) with a PHY
// model that answers read frames and a monitor capturing MDIO at each MDC rising edge.
module tb_mdio_master_controller;

  logic        clk;
  logic        reset;
  logic        transmit_we;
  logic [31:0] transmit_data_in;
  logic        transmit_ready;
  logic        receive_re;
  logic [15:0] receive_data;
  logic        receive_valid;
  logic        busy;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  int          phy_slot;
  logic [15:0] phy_data;
  int          cap_idx;
  logic        cap_out [0:79];
  logic        cap_oe  [0:79];
  int          busy_cycles;

  mdio_master_controller #(
    .CLK_DIV      (2),
    .PREAMBLE_BITS(32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .transmit_we     (transmit_we),
    .transmit_data_in(transmit_data_in),
    .transmit_ready  (transmit_ready),
    .receive_re      (receive_re),
    .receive_data    (receive_data),
    .receive_valid   (receive_valid),
    .busy            (busy),
    .mdc             (mdc),
    .mdio_out        (mdio_out),
    .mdio_oe         (mdio_oe),
    .mdio_in         (mdio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot numbering: 0..31 preamble, 32..45 header, 46..47 TA, 48..63 data, 64 end.
  always @(negedge mdc) phy_slot = phy_slot + 1;

  always_comb begin
    mdio_in = 1'b1;
    if (phy_slot == 47)
      mdio_in = 1'b0;
    else if (phy_slot >= 48 && phy_slot <= 63)
      mdio_in = phy_data[63 - phy_slot];
  end

  always @(posedge mdc) begin
    if (cap_idx < 80) begin
      cap_out[cap_idx] = mdio_out;
      cap_oe[cap_idx]  = mdio_oe;
    end
    cap_idx = cap_idx + 1;
  end

  always @(negedge clk) if (busy) busy_cycles = busy_cycles + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [31:0] word, input logic [15:0] rd);
    phy_data         = rd;
    phy_slot         = 0;
    cap_idx          = 0;
    busy_cycles      = 0;
    transmit_we      = 1'b1;
    transmit_data_in = word;
    @(negedge clk);
    transmit_we      = 1'b0;
    check("accept_busy", {63'd0, busy}, 64'd1);
    check("accept_ready", {63'd0, transmit_ready}, 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_word,
                             input logic [63:0] exp_oe);
    logic [63:0] bits;
    logic [63:0] oes;
    bits = '0;
    oes  = '0;
    for (int i = 0; i < 64; i++) begin
      bits[63 - i] = cap_out[i];
      oes[63 - i]  = cap_oe[i];
    end
    check({tag, "_slots"}, 64'(cap_idx), 64'd65);
    check({tag, "_preamble"}, {32'd0, bits[63:32]}, 64'hFFFF_FFFF);
    check({tag, "_bits"}, {32'd0, bits[31:0]}, {32'd0, exp_word});
    check({tag, "_oe"}, oes, exp_oe);
    check({tag, "_end_out"}, {63'd0, cap_out[64]}, 64'd1);
    check({tag, "_end_oe"}, {63'd0, cap_oe[64]}, 64'd0);
    check({tag, "_busy_len"}, 64'(busy_cycles), 64'd260);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mdc"}, {63'd0, mdc}, 64'd0);
    check({tag, "_oe"}, {63'd0, mdio_oe}, 64'd0);
    check({tag, "_out"}, {63'd0, mdio_out}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_ready"}, {63'd0, transmit_ready}, 64'd1);
    check({tag, "_valid"}, {63'd0, receive_valid}, 64'd0);
    check({tag, "_data"}, {48'd0, receive_data}, 64'd0);
  endtask

  initial begin
    int n;
    phy_slot         = 0;
    phy_data         = 16'h0;
    cap_idx          = 0;
    busy_cycles      = 0;
    reset            = 1'b0;
    transmit_we      = 1'b0;
    transmit_data_in = 32'h0;
    receive_re       = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_release");

    $display("[TB] write frame 508ABEEF");
    start_frame(32'h508A_BEEF, 16'h0);
    wait_idle("wr_timeout");
    check_frame("wr", 32'h508A_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr_valid", {63'd0, receive_valid}, 64'd0);
    check("wr_ready", {63'd0, transmit_ready}, 64'd1);

    $display("[TB] read frame 60880000");
    start_frame(32'h6088_0000, 16'h1234);
    wait_idle("rd_timeout");
    check_frame("rd", 32'h608B_FFFF, 64'hFFFF_FFFF_FFFC_0000);
    check("rd_valid", {63'd0, receive_valid}, 64'd1);
    check("rd_data", {48'd0, receive_data}, 64'h1234);
    receive_re = 1'b1;
    @(negedge clk);
    receive_re = 1'b0;
    check("pop_valid", {63'd0, receive_valid}, 64'd0);
    check("pop_data_held", {48'd0, receive_data}, 64'h1234);
    receive_re = 1'b1;
    @(negedge clk);
    receive_re = 1'b0;
    check("pop_empty_valid", {63'd0, receive_valid}, 64'd0);

    $display("[TB] busy rejection");
    start_frame(32'h5A5A_1234, 16'h0);
    repeat (100) @(negedge clk);
    transmit_we      = 1'b1;
    transmit_data_in = 32'h6FFF_0000;
    @(negedge clk);
    transmit_we = 1'b0;
    wait_idle("rej_timeout");
    check_frame("rej", 32'h5A5A_1234, 64'hFFFF_FFFF_FFFF_FFFF);
    busy_cycles = 0;
    repeat (300) @(negedge clk);
    check("rej_no_second", 64'(busy_cycles), 64'd0);
    check("rej_valid", {63'd0, receive_valid}, 64'd0);

    $display("[TB] overwrite and collision");
    start_frame(32'h6088_0000, 16'hAAAA);
    wait_idle("ow1_timeout");
    check("ow1_data", {48'd0, receive_data}, 64'hAAAA);
    check("ow1_valid", {63'd0, receive_valid}, 64'd1);
    start_frame(32'h6088_0000, 16'h5555);
    repeat (259) @(negedge clk);
    check("ow2_still_busy", {63'd0, busy}, 64'd1);
    check("ow2_old_data", {48'd0, receive_data}, 64'hAAAA);
    receive_re = 1'b1;
    @(negedge clk);
    receive_re = 1'b0;
    check("ow2_done", {63'd0, busy}, 64'd0);
    check("ow2_data", {48'd0, receive_data}, 64'h5555);
    check("ow2_valid", {63'd0, receive_valid}, 64'd1);

    $display("[TB] reset during read data");
    start_frame(32'h6088_0000, 16'h0F0F);
    n = 0;
    while (phy_slot != 56 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_slot", 64'(phy_slot), 64'd56);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_release");

    start_frame(32'h5123_C3A5, 16'h0);
    wait_idle("post_timeout");
    check_frame("post", 32'h5123_C3A5, 64'hFFFF_FFFF_FFFF_FFFF);
    check("post_valid", {63'd0, receive_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mdio_master_controller.md
Name: mdio_master_controller

Overview:
- Sequences the MDIO management interface behind the host-side MDIO register interface.
- Accepts one 32-bit Clause-22 frame word, generates MDC, prepends the preamble and serialises the frame MSB-first on MDIO.
- For read frames, releases the line at turnaround, captures the 16 PHY data bits and presents them as receive data.
- Drives the transmit_ready, receive_valid and busy status bits.

Parameters:
- CLK_DIV, 10, clk cycles per MDC half-period; legal values >= 2.
- PREAMBLE_BITS, 32, count of '1' bits driven before the frame; legal values >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- transmit_we  in  1  command write strobe
- transmit_data_in  in  32  frame word: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data
- transmit_ready  out  1  1 = idle, command accepted
- receive_re  in  1  read-data pop strobe
- receive_data  out  16  last captured read data
- receive_valid  out  1  1 = unread data held
- busy  out  1  1 = frame in progress
- mdc  out  1  management clock
- mdio_out  out  1  MDIO drive value
- mdio_oe  out  1  1 = drive MDIO
- mdio_in  in  1  sampled MDIO pad value

Behaviour:
- Reset (asserted low, async, may occur mid-frame):
  - mdc=0, mdio_out=1, mdio_oe=0.
  - busy=0, transmit_ready=1, receive_valid=0, receive_data=0.
  - FSM returns to IDLE and any partial frame is abandoned.
- Frame type: read when OP=2'b10; every other OP value is a write.
- Accept: command is latched on the clk edge where transmit_we=1 and transmit_ready=1. busy=1 and transmit_ready=0 from the next cycle. transmit_we while busy is ignored, with no queueing.
- MDC generation:
  - Divider counts 0..CLK_DIV-1 only when not IDLE.
  - Each bit slot is one MDC period: low phase, then high phase, each CLK_DIV clk cycles.
  - mdc is 0 in IDLE.
- MDIO drive:
  - mdio_out changes only at the start of a low phase.
  - mdio_in is sampled on the clk cycle in which mdc rises 0->1.
- FSM states:
  - IDLE -> PRE on accept.
  - PRE: PREAMBLE_BITS slots, oe=1, out=1 -> HDR.
  - HDR: bits 31..18, 14 slots, oe=1 -> TA.
  - TA: 2 slots.
    - Write: oe=1, drives bits 17,16.
    - Read: oe=0, out=1, nothing sampled.
    - -> DATA.
  - DATA: 16 slots, bits 15..0.
    - Write: oe=1, drives bits.
    - Read: oe=0, samples mdio_in MSB-first into a shift register.
    - -> END.
  - END: 1 slot, oe=0, out=1.
    - Read: receive_data loaded and receive_valid set on the final cycle of END.
    - -> IDLE.
- Duration: busy stays high exactly (PREAMBLE_BITS+33)*2*CLK_DIV clk cycles, identical for read and write.
- receive_valid:
  - Cleared on the cycle after receive_re=1.
  - receive_re while receive_valid=0 has no effect.
  - A new read completing while receive_valid=1 overwrites receive_data; receive_valid stays 1.
  - Completion and receive_re in the same cycle: completion wins, so new data is loaded and receive_valid=1.
  - Write frames never change receive_data or receive_valid.
- receive_data holds its value until the next read completes or reset.
- Width rules:
  - Bit counter is wide enough for max(PREAMBLE_BITS,16).
  - Divider is $clog2(CLK_DIV) bits.
  - No arithmetic overflow paths.

Test Plan:
- Reset defaults: hold reset=0, then release -> mdc=0, mdio_oe=0, mdio_out=1, busy=0, transmit_ready=1, receive_valid=0, receive_data=16'h0.
- Write frame (CLK_DIV=2, PREAMBLE_BITS=32): transmit_we with 32'h508A_BEEF -> busy high exactly 260 cycles, 32 ones then 0101_00001_00010_10_1011111011101111 seen on mdio_out at MDC rising edges, mdio_oe=1 through DATA, receive_valid stays 0.
- Read frame: transmit_data_in 32'h6088_0000; PHY model drives 0 at second TA slot and 16'h1234 on data slots -> mdio_oe=0 from TA onward, receive_data=16'h1234, receive_valid=1 at end, busy high exactly 260 cycles; receive_re -> receive_valid=0 next cycle.
- Busy rejection: transmit_we pulsed mid-frame with a different word -> ignored, frame bits unchanged, no second frame after IDLE.
- Overwrite/collision: two back-to-back reads returning 16'hAAAA then 16'h5555 with no pop -> receive_data=16'h5555, receive_valid=1; receive_re asserted on the second completion cycle -> receive_valid remains 1.
- Reset mid-read: assert reset during DATA slot 8 -> all outputs immediately at reset values, receive_valid=0; next write frame after release is serialised correctly.
